// File: rtl/led_ctrl.sv
// Four-channel LED controller: register file (CTRL/DUTY/BLINK/STATUS), prescaled timebase, blink and PWM.
// Reads return 1 cycle after rd_en; writes land on the strobe edge; no backpressure, led is registered.
module led_ctrl #(
  parameter int PRESCALE = 1000,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [3:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic [3:0]        led
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_DUTY   = 2'd1;
  localparam logic [1:0] A_BLINK  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic [7:0]    ctrl;
  logic [31:0]   duty;
  logic [15:0]   blink;
  logic [PW-1:0] presc;
  logic [7:0]    pwm_cnt;
  logic [15:0]   blink_cnt;
  logic          phase;
  logic          tick;
  logic [1:0]    sel;
  logic [31:0]   rd_mux;
  logic [3:0]    led_nxt;
  logic          unused_addr;

  assign sel         = addr[3:2];
  assign unused_addr = ^addr[1:0];
  assign tick        = (presc == PW'(PRESCALE - 1));

  // Timebase: free-running, untouched by register writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl  <= '0;
      duty  <= '0;
      blink <= '0;
    end else if (wr_en) begin
      case (sel)
        A_CTRL:  ctrl  <= wdata[7:0];
        A_DUTY:  duty  <= wdata[31:0];
        A_BLINK: blink <= wdata[15:0];
        default: ;
      endcase
    end
  end

  // A BLINK write restarts the half-period from phase 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if ((wr_en && sel == A_BLINK) || blink == 16'd0) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == blink - 16'd1) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      A_CTRL:   rd_mux = {24'd0, ctrl};
      A_DUTY:   rd_mux = duty;
      A_BLINK:  rd_mux = {16'd0, blink};
      A_STATUS: rd_mux = {16'd0, pwm_cnt, 7'd0, phase};
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      case (ctrl[2*i +: 2])
        2'b00:   led_nxt[i] = 1'b0;
        2'b01:   led_nxt[i] = 1'b1;
        2'b10:   led_nxt[i] = phase;
        default: led_nxt[i] = (pwm_cnt < duty[8*i +: 8]);
      endcase
    end
  end

  // Read mux samples pre-write state, so a same-edge write is not visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
      led         <= '0;
    end else begin
      rdata_valid <= rd_en;
      if (rd_en) rdata <= rd_mux;
      led <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl at PRESCALE=2: read scoreboard plus LED timing/duty checks.
module tb_led_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [3:0]  led;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    string       nm;
  } rd_exp_t;

  rd_exp_t sb[$];

  led_ctrl #(.PRESCALE(2), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Monitor: every rdata_valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rdata_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rdata_valid: got rdata 0x%08h, expected no pulse", rdata);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        chk(e.nm, rdata & e.mask, e.exp & e.mask);
      end
    end
  end

  // All tasks are entered and left on a falling edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input logic [31:0] mask, input string nm);
    rd_exp_t e;
    e.exp = exp; e.mask = mask; e.nm = nm;
    sb.push_back(e);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int k;
    int h0, h1, h23;
    logic prev;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_led", {28'd0, led}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_rdata_valid", {31'd0, rdata_valid}, 32'd0);

    // STATUS first, before the first tick can advance the pwm counter.
    rst = 1'b0;
    rd(4'hC, 32'd0, 32'hFFFF_FFFF, "reset_status");
    rd(4'h0, 32'd0, 32'hFFFF_FFFF, "reset_ctrl");
    rd(4'h4, 32'd0, 32'hFFFF_FFFF, "reset_duty");
    rd(4'h8, 32'd0, 32'hFFFF_FFFF, "reset_blink");

    // Static on/off.
    wr(4'h0, 32'h55);
    chk("on_led_not_yet", {28'd0, led}, 32'd0);
    @(negedge clk);
    chk("on_led", {28'd0, led}, 32'hF);
    wr(4'h0, 32'h00);
    @(negedge clk);
    chk("off_led", {28'd0, led}, 32'h0);

    // Blink: half-period of 3 ticks = 6 cycles.
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h02);
    for (int t = 0; t < 2; t++) begin
      prev = led[0];
      k = 0;
      while (led[0] === prev && k < 20) begin @(negedge clk); k++; end
      prev = led[0];
      k = 0;
      while (led[0] === prev && k < 20) begin @(negedge clk); k++; end
      chk("blink_interval", k, 6);
    end
    k = 0;
    while (led[0] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("blink_reached_high", {31'd0, led[0]}, 32'd1);
    @(negedge clk);
    wr(4'h8, 32'd3);
    @(negedge clk);
    chk("blink_rewrite_forces_low", {31'd0, led[0]}, 32'd0);
    k = 1;
    while (led[0] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("blink_restart_in_6_or_7", {31'd0, (k >= 6 && k <= 7)}, 32'd1);

    // PWM: 512 cycles is exactly one 256-tick period.
    wr(4'h4, 32'h0000_FF40);
    wr(4'h0, 32'h0F);
    @(negedge clk);
    h0 = 0; h1 = 0; h23 = 0;
    for (int i = 0; i < 512; i++) begin
      h0  += int'(led[0]);
      h1  += int'(led[1]);
      h23 += int'(led[3:2] != 2'b00);
      @(negedge clk);
    end
    chk("pwm_duty64_high", h0, 128);
    chk("pwm_duty255_high", h1, 510);
    chk("pwm_off_leds", h23, 0);

    wr(4'h0, 32'h30);
    @(negedge clk);
    h0 = 0;
    for (int i = 0; i < 512; i++) begin
      h0 += int'(led != 4'b0000);
      @(negedge clk);
    end
    chk("pwm_duty0_never_high", h0, 0);

    // Same-edge read and write returns the old value.
    wr(4'h4, 32'h34);
    sb.push_back('{exp: 32'h34, mask: 32'hFFFF_FFFF, nm: "rw_same_cycle_old"});
    rd_en = 1'b1; wr_en = 1'b1; addr = 4'h4; wdata = 32'h12;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    rd(4'h4, 32'h12, 32'hFFFF_FFFF, "rw_next_read_new");

    // Masked fields, read-only STATUS, BLINK=0 holds phase.
    wr(4'h0, 32'hFFFF_FFFF);
    rd(4'h0, 32'hFF, 32'hFFFF_FFFF, "ctrl_upper_zero");
    wr(4'h8, 32'hABCD_1234);
    rd(4'h8, 32'h1234, 32'hFFFF_FFFF, "blink_upper_zero");
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'h4, 32'h12, 32'hFFFF_FFFF, "status_write_ignored");
    wr(4'h8, 32'hFFFF_0000);
    rd(4'h8, 32'h0, 32'hFFFF_FFFF, "blink_zero");
    rd(4'hC, 32'h0, 32'hFFFF_00FF, "status_phase0_a");
    cycles(9);
    rd(4'hC, 32'h0, 32'hFFFF_00FF, "status_phase0_b");
    cycles(2);

    // Reset during a read: async clear, no pulse afterwards.
    rd_en = 1'b1; addr = 4'h0; rst = 1'b1;
    #1;
    chk("async_rst_led", {28'd0, led}, 32'd0);
    chk("async_rst_rdata", rdata, 32'd0);
    chk("async_rst_valid", {31'd0, rdata_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0;
    cycles(3);
    rd(4'h0, 32'h0, 32'hFFFF_FFFF, "post_rst_ctrl");
    rd(4'h4, 32'h0, 32'hFFFF_FFFF, "post_rst_duty");
    cycles(3);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000, clk cycles per timebase tick (legal 2..65535).
REQ-002 SHALL have parameter DATA_W, default 32, bus data width (fixed at 32).
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 wr_en  input  1  store strobe from the core, one cycle per write.
REQ-006 rd_en  input  1  load strobe from the core, one cycle per read.
REQ-007 addr  input  4  byte address; addr[1:0] ignored.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  read data.
REQ-010 rdata_valid  output  1  one-cycle pulse qualifying rdata.
REQ-011 led  output  4  LED pins, registered.

Function
REQ-012 Register map: 0x0 CTRL (RW), 0x4 DUTY (RW), 0x8 BLINK (RW), 0xC STATUS (RO).
REQ-013 CTRL[2i+1:2i] = mode of LED i: 00 off, 01 on, 10 blink, 11 pwm; CTRL[31:8] read as 0, writes to them ignored.
REQ-014 DUTY[8i+7:8i] = 8-bit duty of LED i.
REQ-015 BLINK[15:0] = blink half-period in ticks; BLINK[31:16] read as 0.
REQ-016 STATUS[0] = blink phase, STATUS[15:8] = pwm counter, other bits 0; writes to STATUS ignored.
REQ-017 Writes take effect on the clk edge where wr_en=1.
REQ-018 Writes to unmapped addresses are ignored; reads of them return 0.
REQ-019 Read latency is exactly 1 cycle: rd_en at edge N -> rdata valid with rdata_valid=1 after edge N+1.
REQ-020 rdata_valid is 0 on every cycle without a preceding rd_en; rdata holds its last value.
REQ-021 On simultaneous rd_en and wr_en to the same address, the read returns the pre-write value.
REQ-022 Prescaler counts 0..PRESCALE-1 and wraps; tick is a one-cycle pulse when the count equals PRESCALE-1.
REQ-023 The 8-bit pwm counter increments on each tick and wraps 255->0.
REQ-024 The 16-bit blink counter increments on each tick.
- When it equals BLINK-1 on a tick, it clears to 0 and the blink phase toggles.
REQ-025 BLINK=0: blink counter and phase held at 0.
REQ-026 Any write to BLINK clears the blink counter and phase to 0 on the same edge.
REQ-027 Per-LED next value:
- off -> 0
- on -> 1
- blink -> phase
- pwm -> (pwm counter < duty), unsigned compare
REQ-028 Duty 0 gives a constant 0; duty 255 gives 255 high ticks per 256.
REQ-029 led is registered: led reflects mode and counter state one cycle after that state changes.
- Example: a CTRL write at edge N changes led at edge N+1.
REQ-030 The prescaler and pwm counter are never reset by register writes.

Reset
REQ-031 While rst=1, all of the following SHALL be 0 (asynchronously), independent of clk: CTRL, DUTY, BLINK, prescaler, pwm counter, blink counter, phase, led, rdata, rdata_valid.
REQ-032 Reset deasserted mid-read: no rdata_valid pulse for a rd_en sampled while rst=1.
REQ-033 First tick after reset release occurs PRESCALE cycles after the first edge with rst=0.

Verification (PRESCALE=2)
REQ-034 Reset, then read each of 0x0, 0x4, 0x8, 0xC -> rdata=0x0 with rdata_valid=1 one cycle after each rd_en.
REQ-035 Write CTRL=0x55 -> led=4'b1111 one cycle after the write; write CTRL=0x00 -> led=4'b0000 one cycle later.
REQ-036 Write BLINK=3, then CTRL=0x02 -> led[0] toggles every 6 clk cycles; rewriting BLINK=3 mid-phase forces led[0]=0 and restarts the 6-cycle count.
REQ-037 Write DUTY=0x0000_FF40, then CTRL=0x0F:
- led[0] is high for 64 of every 256 ticks (512 cycles).
- led[1] is high for 255 of every 256 ticks.
- led[3:2] stay 0.
REQ-038 Same-cycle rd_en and wr_en to 0x4 with wdata=0x12 while DUTY=0x34 -> rdata=0x34; the next read returns 0x12.
REQ-039 Write 0xFFFF_FFFF to 0xC, and write to 0x8 with BLINK=0 -> STATUS[0] stays 0 and STATUS[31:16] read 0.
